// File: rtl/qs_sort_sched.sv
// Sort scheduler: round-robin claims READY banks from the scoreboard, runs the sort engine
// on one bank at a time and retires it as SORTED (err set on engine error or watchdog expiry).
module qs_sort_sched #(
  parameter int unsigned BankN   = 2,
  parameter int unsigned Timeout = 1024,
  parameter int unsigned AddrW   = 10,
  localparam int unsigned IdxW   = (BankN > 1) ? $clog2(BankN) : 1,
  // Bank state word: {status[1:0], err, n[AddrW-1:0]}
  localparam int unsigned StW    = AddrW + 3,
  localparam int unsigned CntW   = $clog2(Timeout + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [IdxW-1:0]  sb_rd_idx_o,
  input  logic [StW-1:0]   sb_rd_state_i,
  output logic             sb_wr_vld_o,
  output logic [IdxW-1:0]  sb_wr_idx_o,
  output logic [StW-1:0]   sb_wr_state_o,
  input  logic             sb_wr_gnt_i,
  output logic             sort_start_o,
  output logic [IdxW-1:0]  sort_bank_o,
  output logic [AddrW-1:0] sort_n_o,
  input  logic             sort_done_i,
  input  logic             sort_err_i,
  output logic             busy_o
);

  // Status encoding shared with the scoreboard: 0 empty, 1 ready, 2 sorting, 3 sorted.
  localparam logic [1:0] StatReady   = 2'd1;
  localparam logic [1:0] StatSorting = 2'd2;
  localparam logic [1:0] StatSorted  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StStart,
    StBusy,
    StRetire
  } state_e;

  state_e           state_q;
  logic [IdxW-1:0]  scan_ptr_q;
  logic [IdxW-1:0]  sort_bank_q;
  logic [AddrW-1:0] sort_n_q;
  logic             sort_start_q;
  logic             busy_q;
  logic             err_q;
  logic [CntW-1:0]  cnt_q;

  logic [1:0]       rd_status;
  logic [AddrW-1:0] rd_n;
  logic             rd_ready;

  assign rd_status = sb_rd_state_i[StW-1 -: 2];
  assign rd_n      = sb_rd_state_i[AddrW-1:0];
  assign rd_ready  = (rd_status == StatReady);

  function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
    logic [IdxW-1:0] r;
    if (p == IdxW'(BankN - 1)) begin
      r = '0;
    end else begin
      r = p + IdxW'(1);
    end
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      scan_ptr_q   <= '0;
      sort_bank_q  <= '0;
      sort_n_q     <= '0;
      sort_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en_i) begin
            state_q <= StScan;
          end
        end
        StScan: begin
          if (rd_ready) begin
            // Without a grant the claim is retried on the same bank next cycle.
            if (sb_wr_gnt_i) begin
              sort_bank_q  <= scan_ptr_q;
              sort_n_q     <= rd_n;
              busy_q       <= 1'b1;
              sort_start_q <= 1'b1;
              state_q      <= StStart;
            end
          end else begin
            scan_ptr_q <= ptr_inc(scan_ptr_q);
            if (!en_i) begin
              state_q <= StIdle;
            end
          end
        end
        StStart: begin
          sort_start_q <= 1'b0;
          cnt_q        <= '0;
          state_q      <= StBusy;
        end
        StBusy: begin
          cnt_q <= cnt_q + CntW'(1);
          // A completion on the watchdog cycle takes precedence over the timeout.
          if (sort_done_i) begin
            err_q   <= sort_err_i;
            state_q <= StRetire;
          end else if (cnt_q == CntW'(Timeout - 1)) begin
            err_q   <= 1'b1;
            state_q <= StRetire;
          end
        end
        StRetire: begin
          if (sb_wr_gnt_i) begin
            busy_q     <= 1'b0;
            scan_ptr_q <= ptr_inc(sort_bank_q);
            state_q    <= en_i ? StScan : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    sb_rd_idx_o   = (state_q == StRetire) ? sort_bank_q : scan_ptr_q;
    sb_wr_vld_o   = 1'b0;
    sb_wr_idx_o   = sb_rd_idx_o;
    sb_wr_state_o = sb_rd_state_i;
    if (state_q == StScan && rd_ready) begin
      sb_wr_vld_o                = 1'b1;
      sb_wr_state_o[StW-1 -: 2]  = StatSorting;
    end else if (state_q == StRetire) begin
      sb_wr_vld_o                = 1'b1;
      sb_wr_state_o[StW-1 -: 2]  = StatSorted;
      sb_wr_state_o[AddrW]       = err_q;
    end
  end

  assign sort_start_o = sort_start_q;
  assign sort_bank_o  = sort_bank_q;
  assign sort_n_o     = sort_n_q;
  assign busy_o       = busy_q;

  // Handshake invariants.
  a_start_pulse : assert property (@(posedge clk_i) disable iff (rst_i)
    sort_start_q |=> !sort_start_q);
  a_busy_state : assert property (@(posedge clk_i) disable iff (rst_i)
    busy_q == (state_q inside {StStart, StBusy, StRetire}));
  a_wr_state : assert property (@(posedge clk_i) disable iff (rst_i)
    sb_wr_vld_o |-> (state_q inside {StScan, StRetire}));

endmodule

// File: tb/tb_qs_sort_sched.sv
// Bench for qs_sort_sched: the bench acts as scoreboard and sort engine, predicting each
// claim/retire from round-robin order and the watchdog/done rules.
module tb_qs_sort_sched;
  localparam int unsigned BankN   = 3;
  localparam int unsigned Timeout = 16;
  localparam int unsigned AddrW   = 4;
  localparam int unsigned IdxW    = 2;
  localparam int unsigned StW     = AddrW + 3;

  localparam logic [1:0] SEmpty   = 2'd0;
  localparam logic [1:0] SReady   = 2'd1;
  localparam logic [1:0] SSorting = 2'd2;
  localparam logic [1:0] SSorted  = 2'd3;

  logic             clk_i = 1'b0;
  logic             rst_i, en_i, sb_wr_gnt_i, sort_done_i, sort_err_i;
  logic [IdxW-1:0]  sb_rd_idx_o, sb_wr_idx_o, sort_bank_o;
  logic [StW-1:0]   sb_rd_state_i, sb_wr_state_o;
  logic             sb_wr_vld_o, sort_start_o, busy_o;
  logic [AddrW-1:0] sort_n_o;

  always #5 clk_i = ~clk_i;

  qs_sort_sched #(.BankN(BankN), .Timeout(Timeout), .AddrW(AddrW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .sb_rd_idx_o(sb_rd_idx_o), .sb_rd_state_i(sb_rd_state_i),
    .sb_wr_vld_o(sb_wr_vld_o), .sb_wr_idx_o(sb_wr_idx_o), .sb_wr_state_o(sb_wr_state_o),
    .sb_wr_gnt_i(sb_wr_gnt_i), .sort_start_o(sort_start_o), .sort_bank_o(sort_bank_o),
    .sort_n_o(sort_n_o), .sort_done_i(sort_done_i), .sort_err_i(sort_err_i), .busy_o(busy_o)
  );

  // Scoreboard model
  logic [1:0]       m_st  [BankN];
  logic             m_err [BankN];
  logic [AddrW-1:0] m_n   [BankN];

  always_comb begin
    sb_rd_state_i = '0;
    if (int'(sb_rd_idx_o) < BankN) sb_rd_state_i = {m_st[sb_rd_idx_o], m_err[sb_rd_idx_o], m_n[sb_rd_idx_o]};
  end

  int total = 0;
  int bad   = 0;
  int rr_next = 0;

  typedef struct {
    int d; bit use_done; bit err_in; bit exp_err; int exp_lat;
  } tcase_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at negedge+1 after inputs settle: applies granted write after the edge.
  task automatic tick();
    bit w; logic [IdxW-1:0] wi; logic [StW-1:0] ws;
    w = sb_wr_vld_o && sb_wr_gnt_i; wi = sb_wr_idx_o; ws = sb_wr_state_o;
    @(posedge clk_i); #1;
    if (w && int'(wi) < BankN) begin
      m_st[wi] = ws[StW-1 -: 2]; m_err[wi] = ws[AddrW]; m_n[wi] = ws[AddrW-1:0];
    end
    sort_done_i = 1'b0; sort_err_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; sb_wr_gnt_i = 1'b0; sort_done_i = 1'b0; sort_err_i = 1'b0;
    for (int i = 0; i < BankN; i++) begin m_st[i] = SEmpty; m_err[i] = 1'b0; m_n[i] = '0; end
    #1; tick(); tick();
    rst_i = 1'b0; rr_next = 0;
  endtask

  function automatic int find_ready(input int start);
    for (int k = 0; k < BankN; k++) if (m_st[(start + k) % BankN] == SReady) return (start + k) % BankN;
    return -1;
  endfunction

  task automatic mark_ready(input int b);
    m_st[b] = SReady; m_err[b] = 1'($urandom_range(1)); m_n[b] = AddrW'($urandom);
  endtask

  task automatic maybe_mark(input int job, input bit force_one);
    int b; bit any;
    any = 1'b0;
    for (int i = 0; i < BankN; i++) if (i != job && m_st[i] == SReady) any = 1'b1;
    if (force_one && !any) begin
      mark_ready((job + 1 + int'($urandom_range(BankN - 2))) % BankN);
    end else if ($urandom_range(3) == 0) begin
      b = int'($urandom_range(BankN - 1));
      if (b != job && m_st[b] != SReady) mark_ready(b);
    end
  endtask

  // One complete job: claim, start pulse, sort, retire. Expected bank is the first READY
  // bank in round-robin order from rr_next.
  task automatic run_job(input int d, input bit use_done, input bit err_in, input bit exp_err,
                         input int exp_lat, input int gnt_pct, input int hold, input bit mark_more,
                         input bit drop_en, output int claim_t, output int n_wait);
    int exp_bank, first_vld; logic [AddrW-1:0] exp_n; logic exp_e0; bit got, start_seen;
    claim_t = -1; n_wait = 0;
    exp_bank = find_ready(rr_next);
    if (exp_bank < 0) begin check("ready bank in model", 64'(0), 64'(1)); return; end
    exp_n = m_n[exp_bank]; exp_e0 = m_err[exp_bank];
    got = 1'b0; start_seen = 1'b0;
    for (int t = 0; t < 64 && !got; t++) begin
      sb_wr_gnt_i = (n_wait >= hold) && ($urandom_range(99) < gnt_pct);
      #1;
      start_seen |= sort_start_o;
      if (sb_wr_vld_o && sb_wr_gnt_i) begin
        got = 1'b1; claim_t = t;
        check("claim write", 64'({sb_wr_idx_o, sb_wr_state_o}),
              64'({IdxW'(exp_bank), SSorting, exp_e0, exp_n}));
      end else if (sb_wr_vld_o) begin
        n_wait++;
      end
      tick();
    end
    check("no start before grant", 64'(start_seen), 64'(0));
    if (!got) begin check("claim within bound", 64'(0), 64'(1)); return; end
    if (drop_en) en_i = 1'b0;
    sb_wr_gnt_i = 1'b0; #1;
    check("start pulse", 64'(sort_start_o), 64'(1));
    check("sort bank", 64'(sort_bank_o), 64'(exp_bank));
    check("sort n", 64'(sort_n_o), 64'(exp_n));
    check("busy", 64'(busy_o), 64'(1));
    tick();
    first_vld = -1; got = 1'b0;
    for (int c = 1; c < 80 && !got; c++) begin
      if (use_done && c == d) begin sort_done_i = 1'b1; sort_err_i = err_in; end
      if (mark_more) maybe_mark(exp_bank, c == 1);
      sb_wr_gnt_i = ($urandom_range(99) < gnt_pct);
      #1;
      if (c == 1) check("start one cycle", 64'(sort_start_o), 64'(0));
      if (sb_wr_vld_o && first_vld < 0) first_vld = c;
      if (sb_wr_vld_o && sb_wr_gnt_i) begin
        got = 1'b1;
        check("retire write", 64'({sb_wr_idx_o, sb_wr_state_o}),
              64'({IdxW'(exp_bank), SSorted, exp_err, exp_n}));
      end
      tick();
    end
    if (!got) check("retire within bound", 64'(0), 64'(1));
    check("retire latency", 64'(first_vld), 64'(exp_lat));
    rr_next = (exp_bank + 1) % BankN;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tcase_t tab[6];
    int ct, nw, cnt;
    tab[0] = '{d: 1,  use_done: 1'b1, err_in: 1'b0, exp_err: 1'b0, exp_lat: 2};
    tab[1] = '{d: 4,  use_done: 1'b1, err_in: 1'b1, exp_err: 1'b1, exp_lat: 5};
    tab[2] = '{d: 15, use_done: 1'b1, err_in: 1'b0, exp_err: 1'b0, exp_lat: 16};
    tab[3] = '{d: 16, use_done: 1'b1, err_in: 1'b1, exp_err: 1'b1, exp_lat: 17};
    tab[4] = '{d: 16, use_done: 1'b1, err_in: 1'b0, exp_err: 1'b0, exp_lat: 17};
    tab[5] = '{d: 0,  use_done: 1'b0, err_in: 1'b0, exp_err: 1'b1, exp_lat: 17};

    rst_i = 1'b1; en_i = 1'b0; sb_wr_gnt_i = 1'b0; sort_done_i = 1'b0; sort_err_i = 1'b0;
    @(negedge clk_i);

    // Reset values and parking while disabled
    do_reset(); #1;
    check("reset busy", 64'(busy_o), 64'(0));
    check("reset start", 64'(sort_start_o), 64'(0));
    check("reset bank", 64'(sort_bank_o), 64'(0));
    check("reset n", 64'(sort_n_o), 64'(0));
    check("reset wr_vld", 64'(sb_wr_vld_o), 64'(0));
    m_st[0] = SReady; m_n[0] = AddrW'(7);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin #1; if (sb_wr_vld_o) cnt++; tick(); end
    check("idle no writes", 64'(cnt), 64'(0));

    // Bank0 n=7 claimed one cycle after enable
    en_i = 1'b1;
    run_job(3, 1'b1, 1'b0, 1'b0, 4, 100, 0, 1'b0, 1'b0, ct, nw);
    check("first claim cycle", 64'(ct), 64'(1));

    // Fairness: bank0, then bank1, then wrap past empty bank2 back to bank0
    do_reset();
    m_st[0] = SReady; m_n[0] = AddrW'(3);
    m_st[1] = SReady; m_n[1] = AddrW'(9); m_err[1] = 1'b1;
    en_i = 1'b1;
    run_job(2, 1'b1, 1'b0, 1'b0, 3, 100, 0, 1'b0, 1'b0, ct, nw);
    m_st[0] = SReady; m_n[0] = AddrW'(11);
    run_job(5, 1'b1, 1'b1, 1'b1, 6, 100, 0, 1'b0, 1'b0, ct, nw);
    check("resume claim cycle", 64'(ct), 64'(0));
    run_job(1, 1'b1, 1'b0, 1'b0, 2, 100, 0, 1'b0, 1'b0, ct, nw);
    check("wrap claim cycle", 64'(ct), 64'(1));

    // Grant withheld three cycles
    do_reset();
    m_st[1] = SReady; m_n[1] = AddrW'(5);
    en_i = 1'b1;
    run_job(2, 1'b1, 1'b0, 1'b0, 3, 100, 3, 1'b0, 1'b0, ct, nw);
    check("held vld cycles", 64'(nw), 64'(3));
    check("held claim cycle", 64'(ct), 64'(5));

    // Done / error / watchdog boundary table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      m_st[i % BankN] = SReady; m_n[i % BankN] = AddrW'(i + 1);
      en_i = 1'b1;
      run_job(tab[i].d, tab[i].use_done, tab[i].err_in, tab[i].exp_err, tab[i].exp_lat,
              100, 0, 1'b0, 1'b0, ct, nw);
    end

    // Enable dropped mid-job: job completes, scheduler parks, resumes after retired bank
    do_reset();
    m_st[0] = SReady; m_n[0] = AddrW'(2);
    en_i = 1'b1;
    run_job(2, 1'b1, 1'b0, 1'b0, 3, 100, 0, 1'b0, 1'b1, ct, nw);
    m_st[2] = SReady; m_n[2] = AddrW'(13);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin #1; if (sb_wr_vld_o) cnt++; tick(); end
    check("parked no writes", 64'(cnt), 64'(0));
    en_i = 1'b1;
    run_job(1, 1'b1, 1'b1, 1'b1, 2, 100, 0, 1'b0, 1'b0, ct, nw);
    check("unpark claim cycle", 64'(ct), 64'(2));

    // Reset while busy drops the job
    do_reset();
    m_st[0] = SReady; m_n[0] = AddrW'(6);
    en_i = 1'b1; sb_wr_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin #1; tick(); end
    #1;
    check("busy before reset", 64'(busy_o), 64'(1));
    rst_i = 1'b1; #1; tick();
    rst_i = 1'b0; en_i = 1'b0;
    for (int i = 0; i < BankN; i++) begin m_st[i] = SEmpty; m_err[i] = 1'b0; m_n[i] = '0; end
    #1;
    check("reset-in-busy busy", 64'(busy_o), 64'(0));
    check("reset-in-busy start", 64'(sort_start_o), 64'(0));
    check("reset-in-busy vld", 64'(sb_wr_vld_o), 64'(0));
    // Stray done while idle is ignored
    sort_done_i = 1'b1; sort_err_i = 1'b1; tick();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin #1; if (sb_wr_vld_o || busy_o) cnt++; tick(); end
    check("stray done ignored", 64'(cnt), 64'(0));

    // Randomized jobs with random grants, durations and arrivals
    do_reset();
    for (int i = 0; i < BankN; i++) if ($urandom_range(1) == 1) mark_ready(i);
    if (find_ready(0) < 0) mark_ready(int'($urandom_range(BankN - 1)));
    en_i = 1'b1;
    for (int j = 0; j < 30; j++) begin
      int d; bit ud, e;
      d  = int'($urandom_range(1, 20));
      ud = (d <= Timeout);
      e  = 1'($urandom_range(1));
      run_job(d, ud, e, ud ? e : 1'b1, ud ? d + 1 : Timeout + 1, 70, 0, 1'b1, 1'b0, ct, nw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
